// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, bit-timing helper and parity sense shared by the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_e;
  localparam logic PARITY_ODD = 1'b1;
  function automatic int clocks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, received byte, error flags and consumer acknowledge
interface uart_rx_if;
  logic       rx;
  logic       read_ack;
  logic [7:0] data;
  logic       valid;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;
  modport slave (input rx, read_ack, output data, valid, parity_error, framing_error, overrun);
  modport master (output rx, read_ack, input data, valid, parity_error, framing_error, overrun);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchronizer, bit-period counter and 3-sample majority vote
module uart_rx_sampler #(
  parameter int CPB = 104
) (
  input  logic clock,
  input  logic reset,
  input  logic rx_i,
  input  logic cnt_clr_i,
  output logic rx_s_o,
  output logic fall_edge_o,
  output logic sample_vld_o,
  output logic sample_bit_o,
  output logic bit_end_o
);
  localparam int W = $clog2(CPB + 1);
  localparam logic [W-1:0] LAST = W'(CPB - 1);
  localparam logic [W-1:0] SMP = W'(CPB / 2 + 1);
  logic [1:0]   sync_q;
  logic [1:0]   hist_q;
  logic [W-1:0] cnt_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= '1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      hist_q <= {hist_q[0], sync_q[1]};
      cnt_q  <= (cnt_clr_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end
  // the vote fires one cycle after mid so mid-1, mid, mid+1 are all available
  assign rx_s_o       = sync_q[1];
  assign fall_edge_o  = hist_q[0] & ~sync_q[1];
  assign sample_vld_o = cnt_q == SMP;
  assign sample_bit_o = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign bit_end_o    = cnt_q == LAST;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8O1 frame receiver with hold-until-ack output and parity/framing/overrun flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input logic       clock,
  input logic       reset,
  uart_rx_if.slave  bus
);
  localparam int CPB = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
  uart_state_e state_q;
  logic [7:0]  shift_q, data_q;
  logic [2:0]  bit_pos_q;
  logic        par_q, valid_q, pe_q, fe_q, ovr_q;
  logic        rx_s, fall_edge, smp_vld, smp_bit, bit_end, done, parity_ok;
  uart_rx_sampler #(.CPB(CPB)) u_sampler (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (bus.rx),
    .cnt_clr_i   (state_q == IDLE && !fall_edge),
    .rx_s_o      (rx_s),
    .fall_edge_o (fall_edge),
    .sample_vld_o(smp_vld),
    .sample_bit_o(smp_bit),
    .bit_end_o   (bit_end)
  );
  assign done      = state_q == STOP && smp_vld;
  assign parity_ok = (^shift_q ^ par_q) == PARITY_ODD;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_pos_q <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE:   if (fall_edge) state_q <= START;
        START:  if (smp_vld && smp_bit) state_q <= IDLE;
                else if (bit_end) begin
                  state_q   <= DATA;
                  bit_pos_q <= '0;
                end
        DATA: begin
          if (smp_vld) shift_q[bit_pos_q] <= smp_bit;
          if (bit_end) begin
            bit_pos_q <= bit_pos_q + 3'd1;
            if (bit_pos_q == 3'd7) state_q <= PARITY;
          end
        end
        PARITY: begin
          if (smp_vld) par_q <= smp_bit;
          if (bit_end) state_q <= STOP;
        end
        // a low stop bit parks in WAIT_HIGH so a stuck line yields a single byte
        STOP:      if (smp_vld) state_q <= smp_bit ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (rx_s) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
      if (done && (!valid_q || bus.read_ack)) begin
        data_q  <= shift_q;
        pe_q    <= ~parity_ok;
        fe_q    <= ~smp_bit;
        valid_q <= 1'b1;
        ovr_q   <= 1'b0;
      end else if (done) ovr_q <= 1'b1;
      else if (bus.read_ack && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end
  assign bus.data          = data_q;
  assign bus.valid         = valid_q;
  assign bus.parity_error  = pe_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving 8O1 frames into uart_rx
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CPB = clocks_per_bit(12_000_000, 115_200);
  localparam int LAT = (21 * CPB) / 2 + 3;
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0, total = 0, rises = 0, lat = 0;
  logic valid_d = 1'b0;
  exp_t sb[$];
  exp_t e;
  bit   ok;
  always #5 clock = ~clock;
  uart_rx_if bus();
  uart_rx dut (.clock(clock), .reset(reset), .bus(bus));
  always @(posedge clock) begin
    valid_d <= bus.valid;
    if (bus.valid && !valid_d) rises <= rises + 1;
  end
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
    $fatal(1);
  end
  task automatic bit_time(input logic v);
    bus.rx = v;
    repeat (CPB) @(negedge clock);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit push);
    if (push) sb.push_back('{d, (^d ^ p) != PARITY_ODD, !s});
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(p);
    bit_time(s);
  endtask
  task automatic wait_valid(output bit got);
    int n = 0;
    got = bus.valid === 1'b1;
    while (!got && n < 20 * CPB) begin
      @(negedge clock);
      n++;
      got = bus.valid === 1'b1;
    end
  endtask
  task automatic ack();
    @(negedge clock) bus.read_ack = 1'b1;
    @(negedge clock) bus.read_ack = 1'b0;
  endtask
  task automatic test_reset();
    bus.rx = 1'b1;
    bus.read_ack = 1'b0;
    reset = 1'b1;
    repeat (50) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b need 0", bus.valid);
    else passed++;
    total++;
    if ({bus.data, bus.parity_error, bus.framing_error, bus.overrun} !== 11'd0)
      $display("FAIL reset_outputs: data=%h pe=%b fe=%b ovr=%b need all 0", bus.data,
               bus.parity_error, bus.framing_error, bus.overrun);
    else passed++;
  endtask
  task automatic test_basic();
    bit bad = 0;
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    wait_valid(ok);
    e = sb.pop_front();
    total++;
    if (!ok || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
      $display("FAIL basic_a5: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b", bus.valid,
               bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
    else passed++;
    repeat (1000) begin
      @(negedge clock);
      if (bus.valid !== 1'b1 || bus.data !== 8'hA5) bad = 1;
    end
    total++;
    if (bad) $display("FAIL hold_stable: valid=%b data=%h need 1/a5", bus.valid, bus.data);
    else passed++;
    ack();
    total++;
    if (bus.valid !== 1'b0) $display("FAIL ack_clears: valid=%b need 0", bus.valid);
    else passed++;
  endtask
  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h01, k == 0, 1'b1, 1);
      wait_valid(ok);
      e = sb.pop_front();
      total++;
      if (!ok || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
        $display("FAIL parity_%0d: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b", k,
                 bus.valid, bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
      else passed++;
      ack();
    end
  endtask
  task automatic test_framing();
    int r0 = rises;
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    total++;
    if (!ok || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
      $display("FAIL framing_3c: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b", bus.valid,
               bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
    else passed++;
    total++;
    if (rises - r0 !== 1) $display("FAIL framing_once: %0d valid pulses, need 1", rises - r0);
    else passed++;
    ack();
    repeat (2 * CPB) @(negedge clock);
    total++;
    if (bus.valid !== 1'b0) $display("FAIL framing_no_extra: valid=%b need 0", bus.valid);
    else passed++;
    send_frame(8'h55, 1'b1, 1'b1, 1);
    wait_valid(ok);
    e = sb.pop_front();
    total++;
    if (!ok || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
      $display("FAIL after_break_55: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b",
               bus.valid, bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
    else passed++;
    ack();
  endtask
  task automatic test_glitch();
    int r0 = rises;
    bus.rx = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    total++;
    if (bus.valid !== 1'b0 || rises !== r0)
      $display("FAIL glitch: valid=%b pulses=%0d need 0/0", bus.valid, rises - r0);
    else passed++;
  endtask
  task automatic test_back_to_back();
    send_frame(8'h12, 1'b1, 1'b1, 1);
    send_frame(8'h34, 1'b0, 1'b1, 0);
    bit_time(1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    total++;
    if (!ok || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
      $display("FAIL overrun_keep_12: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b",
               bus.valid, bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
    else passed++;
    total++;
    if (bus.overrun !== 1'b1) $display("FAIL overrun_set: got %b need 1", bus.overrun);
    else passed++;
    ack();
    total++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b0)
      $display("FAIL overrun_ack: valid=%b ovr=%b need 0/0", bus.valid, bus.overrun);
    else passed++;
  endtask
  task automatic test_reset_midframe();
    int r0 = rises;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    repeat (CPB / 2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (CPB - CPB / 2 - 3) @(negedge clock);
    for (int i = 0; i < 7; i++) bit_time(1'b1);
    total++;
    if (bus.valid !== 1'b0 || rises !== r0)
      $display("FAIL reset_abort: valid=%b pulses=%0d need 0/0", bus.valid, rises - r0);
    else passed++;
    fork
      send_frame(8'h81, 1'b1, 1'b1, 1);
      begin
        lat = 0;
        while (bus.valid !== 1'b1 && lat < 2000) begin
          @(posedge clock);
          lat++;
          #1;
        end
      end
    join
    total++;
    if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL latency: %0d clocks need %0d+-1", lat, LAT);
    else passed++;
    e = sb.pop_front();
    total++;
    if (bus.valid !== 1'b1 || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
      $display("FAIL after_reset_81: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b",
               bus.valid, bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
    else passed++;
  endtask
  task automatic test_ack_coincident();
    fork
      send_frame(8'h7E, 1'b1, 1'b1, 1);
      begin
        repeat (lat - 1) @(posedge clock);
        #1 bus.read_ack = 1'b1;
        @(posedge clock);
        #1 bus.read_ack = 1'b0;
      end
    join
    e = sb.pop_front();
    total++;
    if (bus.valid !== 1'b1 || bus.data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe)
      $display("FAIL coincident_7e: valid=%b data=%h pe=%b fe=%b need data=%h pe=%b fe=%b",
               bus.valid, bus.data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
    else passed++;
    total++;
    if (bus.overrun !== 1'b0) $display("FAIL coincident_ovr: got %b need 0", bus.overrun);
    else passed++;
    ack();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_ack_coincident();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
